cook_timer_ctrl: RTL and testbench

//  Parametrised microwave cook controller; successor to the fixed-function microwave core.
//  - Takes debounced one-cycle button pulses and the power switch.
//  - Keeps a settable countdown in seconds.
//  - Drives magnetron PWM (selectable power level), turntable motor direction and done LED.
//  - Sits between btn_debounce and the fnd display driver, which shows remain_sec.

---
 rtl/cook_timer_ctrl_pkg.sv | 11 +
 rtl/cook_timer_ctrl_pwm_gen.sv | 23 ++
 rtl/cook_timer_ctrl.sv | 142 ++++++++++++++
 tb/tb_cook_timer_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cook_timer_ctrl_pkg.sv
// cook_timer_ctrl_pkg: shared state encoding and motor drive constants
package cook_timer_ctrl_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
    localparam logic [1:0] MOTOR_FWD = 2'b10;
    localparam logic [1:0] MOTOR_OFF = 2'b00;
endpackage

// File: rtl/cook_timer_ctrl_pwm_gen.sv
// cook_timer_ctrl_pwm_gen: magnetron PWM with level-selected duty; frame counter parked at 0 while disabled
module cook_timer_ctrl_pwm_gen #(
    parameter int PERIOD = 100,
    parameter int LEVELS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [$clog2(LEVELS)-1:0]  level,
    output logic                       pwm
);
    localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    logic [PW-1:0] cnt;
    logic [31:0]   duty;
    // frame counter runs 0..PERIOD-1 only while enabled, so every run starts on a frame boundary
    always_ff @(posedge clk) begin
        if (rst || !en) cnt <= '0;
        else cnt <= (cnt == PW'(PERIOD - 1)) ? '0 : cnt + PW'(1);
    end
    // high-time threshold; the top level reaches a full frame
    always_comb duty = (32'(level) + 32'd1) * 32'(PERIOD) / 32'(LEVELS);
    assign pwm = en && (32'(cnt) < duty);
endmodule

// File: rtl/cook_timer_ctrl.sv
// cook_timer_ctrl: microwave cook FSM with second divider, saturating countdown, done timer and PWM power control
module cook_timer_ctrl
    import cook_timer_ctrl_pkg::*;
#(
    parameter int TICK_CYCLES = 100_000_000,
    parameter int MAX_SEC     = 5999,
    parameter int ADD_STEP    = 30,
    parameter int NUM_LEVELS  = 4,
    parameter int PWM_PERIOD  = 100,
    parameter int DONE_SEC    = 3,
    parameter int TIME_W      = 13
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sw0,
    input  logic                          btn_add,
    input  logic                          btn_start,
    input  logic                          btn_stop,
    input  logic                          btn_level,
    output logic [TIME_W-1:0]             remain_sec,
    output logic [$clog2(NUM_LEVELS)-1:0] level,
    output logic                          pwm_out,
    output logic [1:0]                    motor_dir,
    output logic                          led_done,
    output logic                          busy
);
    localparam int LW = $clog2(NUM_LEVELS);
    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int DW = $clog2(DONE_SEC + 1);
    state_t            state, state_nx;
    logic [TIME_W-1:0] sec, sec_nx, sec_add, sec_run;
    logic [TIME_W:0]   sum;
    logic [LW-1:0]     lvl, lvl_nx;
    logic [CW-1:0]     tick, tick_nx, tick_inc;
    logic [DW-1:0]     dcnt, dcnt_nx;
    logic              wrap, do_start, do_add, do_level, any_btn;

    assign do_start = btn_start && !btn_stop;
    assign do_add   = btn_add && !btn_stop && !btn_start;
    assign do_level = btn_level && !btn_stop && !btn_start && !btn_add;
    assign any_btn  = btn_add || btn_start || btn_stop || btn_level;
    assign sum      = {1'b0, sec} + (TIME_W + 1)'(ADD_STEP);
    assign sec_add  = (sum > (TIME_W + 1)'(MAX_SEC)) ? TIME_W'(MAX_SEC) : sum[TIME_W-1:0];
    assign sec_run  = do_add ? sec_add : sec;
    assign wrap     = tick == CW'(TICK_CYCLES - 1);
    assign tick_inc = wrap ? '0 : tick + CW'(1);

    // state and datapath registers; reset restores the top power level
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            sec   <= '0;
            lvl   <= LW'(NUM_LEVELS - 1);
            tick  <= '0;
            dcnt  <= '0;
        end else begin
            state <= state_nx;
            sec   <= sec_nx;
            lvl   <= lvl_nx;
            tick  <= tick_nx;
            dcnt  <= dcnt_nx;
        end
    end

    // next state: one prioritised button action per cycle, countdown on tick wrap, power switch overrides all
    always_comb begin
        state_nx = state;
        sec_nx   = sec;
        lvl_nx   = lvl;
        tick_nx  = tick;
        dcnt_nx  = dcnt;
        case (state)
            ST_IDLE: begin
                tick_nx = '0;
                dcnt_nx = '0;
                if (do_start) begin
                    if (sec != '0) state_nx = ST_RUN;
                end else if (do_add) begin
                    sec_nx = sec_add;
                end else if (do_level) begin
                    lvl_nx = (lvl == LW'(NUM_LEVELS - 1)) ? '0 : lvl + LW'(1);
                end
            end
            ST_RUN: begin
                if (btn_stop) begin
                    state_nx = ST_PAUSE;
                end else begin
                    tick_nx = tick_inc;
                    sec_nx  = wrap ? sec_run - TIME_W'(1) : sec_run;
                    if (wrap && sec_run == TIME_W'(1)) state_nx = ST_DONE;
                end
            end
            ST_PAUSE: begin
                if (btn_stop) begin
                    state_nx = ST_IDLE;
                    sec_nx   = '0;
                    tick_nx  = '0;
                end else if (do_start) begin
                    state_nx = ST_RUN;
                end else if (do_add) begin
                    sec_nx = sec_add;
                end
            end
            ST_DONE: begin
                if (any_btn) begin
                    state_nx = ST_IDLE;
                    tick_nx  = '0;
                    dcnt_nx  = '0;
                end else begin
                    tick_nx = tick_inc;
                    if (wrap) begin
                        dcnt_nx  = (dcnt == DW'(DONE_SEC - 1)) ? '0 : dcnt + DW'(1);
                        state_nx = (dcnt == DW'(DONE_SEC - 1)) ? ST_IDLE : ST_DONE;
                    end
                end
            end
        endcase
        if (!sw0) begin
            state_nx = ST_IDLE;
            sec_nx   = '0;
            tick_nx  = '0;
            dcnt_nx  = '0;
        end
    end

    cook_timer_ctrl_pwm_gen #(
        .PERIOD(PWM_PERIOD),
        .LEVELS(NUM_LEVELS)
    ) u_pwm (
        .clk  (clk),
        .rst  (rst),
        .en   (state == ST_RUN),
        .level(lvl),
        .pwm  (pwm_out)
    );

    assign remain_sec = sec;
    assign level      = lvl;
    assign motor_dir  = (state == ST_RUN) ? MOTOR_FWD : MOTOR_OFF;
    assign led_done   = state == ST_DONE;
    assign busy       = (state == ST_RUN) || (state == ST_PAUSE);
endmodule

// File: tb/tb_cook_timer_ctrl.sv
// tb_cook_timer_ctrl: directed scenarios plus random button traffic, checked against a behavioural cook model
module tb_cook_timer_ctrl;
    localparam int TICK = 10, PER = 8, LEV = 4, ADD = 30, MAXS = 100, DSEC = 3, TW = 7;
    localparam int MI = 0, MR = 1, MP = 2, MD = 3;

    logic          clk = 1'b0;
    logic          rst, sw0, btn_add, btn_start, btn_stop, btn_level;
    logic [TW-1:0] remain_sec;
    logic [1:0]    level;
    logic          pwm_out;
    logic [1:0]    motor_dir;
    logic          led_done, busy;

    int checks = 0, failures = 0;
    int m_mode, m_sec, m_lvl, m_sub, m_dsec, m_age;
    int highs;

    cook_timer_ctrl #(
        .TICK_CYCLES(TICK), .MAX_SEC(MAXS), .ADD_STEP(ADD), .NUM_LEVELS(LEV),
        .PWM_PERIOD(PER), .DONE_SEC(DSEC), .TIME_W(TW)
    ) dut (
        .clk(clk), .rst(rst), .sw0(sw0), .btn_add(btn_add), .btn_start(btn_start),
        .btn_stop(btn_stop), .btn_level(btn_level), .remain_sec(remain_sec), .level(level),
        .pwm_out(pwm_out), .motor_dir(motor_dir), .led_done(led_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > MAXS) ? MAXS : v;
    endfunction

    // one clock of the cook rules: elapsed cycles within the current second in m_sub, pwm phase in m_age
    task automatic model_step(input bit a, input bit st, input bit sp, input bit lv, input bit sw);
        int old = m_mode;
        bit start_act = st && !sp;
        bit add_act = a && !sp && !st;
        bit lvl_act = lv && !sp && !st && !a;
        if (!sw) begin
            m_mode = MI; m_sec = 0; m_sub = 0; m_dsec = 0;
        end else if (m_mode == MI) begin
            if (start_act) begin
                if (m_sec > 0) begin m_mode = MR; m_sub = 0; end
            end else if (add_act) m_sec = sat(m_sec + ADD);
            else if (lvl_act) m_lvl = (m_lvl + 1) % LEV;
        end else if (m_mode == MR) begin
            if (sp) m_mode = MP;
            else begin
                if (add_act) m_sec = sat(m_sec + ADD);
                m_sub = m_sub + 1;
                if (m_sub == TICK) begin
                    m_sub = 0;
                    m_sec = m_sec - 1;
                    if (m_sec == 0) begin m_mode = MD; m_dsec = 0; end
                end
            end
        end else if (m_mode == MP) begin
            if (sp) begin m_mode = MI; m_sec = 0; m_sub = 0; end
            else if (start_act) m_mode = MR;
            else if (add_act) m_sec = sat(m_sec + ADD);
        end else begin
            if (a || st || sp || lv) begin m_mode = MI; m_sub = 0; m_dsec = 0; end
            else begin
                m_sub = m_sub + 1;
                if (m_sub == TICK) begin
                    m_sub = 0;
                    m_dsec = m_dsec + 1;
                    if (m_dsec == DSEC) begin m_mode = MI; m_dsec = 0; end
                end
            end
        end
        m_age = (old == MR) ? (m_age + 1) % PER : 0;
    endtask

    task automatic compare_all();
        check("remain", int'(remain_sec), m_sec);
        check("level", int'(level), m_lvl);
        check("pwm", int'(pwm_out), (m_mode == MR && m_age < (m_lvl + 1) * PER / LEV) ? 1 : 0);
        check("motor", int'(motor_dir), (m_mode == MR) ? 2 : 0);
        check("led_done", int'(led_done), (m_mode == MD) ? 1 : 0);
        check("busy", int'(busy), (m_mode == MR || m_mode == MP) ? 1 : 0);
    endtask

    task automatic cycle(input bit a, input bit st, input bit sp, input bit lv, input bit sw);
        btn_add = a; btn_start = st; btn_stop = sp; btn_level = lv; sw0 = sw;
        @(posedge clk);
        model_step(a, st, sp, lv, sw);
        #1;
        compare_all();
        btn_add = 0; btn_start = 0; btn_stop = 0; btn_level = 0; sw0 = 1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(0, 0, 0, 0, 1);
    endtask

    initial begin
        bit a, st, sp, lv, sw;
        int rate, pick;
        rst = 1; sw0 = 1; btn_add = 0; btn_start = 0; btn_stop = 0; btn_level = 0;
        repeat (3) @(posedge clk);
        #1;
        m_mode = MI; m_sec = 0; m_lvl = LEV - 1; m_sub = 0; m_dsec = 0; m_age = 0;
        compare_all();
        check("rst_level", int'(level), 3);
        check("rst_remain", int'(remain_sec), 0);
        rst = 0;

        cycle(1, 0, 0, 0, 1); cycle(1, 0, 0, 0, 1);
        check("t1_add60", int'(remain_sec), 60);
        cycle(0, 1, 0, 0, 1);
        check("t1_busy", int'(busy), 1);
        check("t1_motor", int'(motor_dir), 2);
        idle(9);
        check("t1_hold60", int'(remain_sec), 60);
        idle(1);
        check("t1_dec59", int'(remain_sec), 59);
        cycle(0, 0, 1, 0, 1); cycle(0, 0, 1, 0, 1);
        check("t1_clear", int'(remain_sec), 0);

        for (int i = 1; i <= 5; i++) begin
            cycle(1, 0, 0, 0, 1);
            check("t2_sat", int'(remain_sec), (i * 30 > 100) ? 100 : i * 30);
        end
        cycle(0, 0, 0, 0, 0);
        check("t2_sw_clear", int'(remain_sec), 0);

        cycle(1, 0, 0, 0, 1); cycle(0, 1, 0, 0, 1);
        idle(280);
        check("t3_at2", int'(remain_sec), 2);
        idle(19);
        check("t3_not_done", int'(led_done), 0);
        idle(1);
        check("t3_done", int'(led_done), 1);
        check("t3_done_busy", int'(busy), 0);
        idle(29);
        check("t3_done_hold", int'(led_done), 1);
        idle(1);
        check("t3_idle_led", int'(led_done), 0);
        check("t3_idle_remain", int'(remain_sec), 0);
        check("t3_idle_motor", int'(motor_dir), 0);
        check("t3_idle_pwm", int'(pwm_out), 0);

        cycle(1, 0, 0, 0, 1); cycle(0, 1, 0, 0, 1);
        idle(4);
        cycle(0, 0, 1, 0, 1);
        check("t4_pause_busy", int'(busy), 1);
        check("t4_pause_motor", int'(motor_dir), 0);
        idle(50);
        check("t4_frozen", int'(remain_sec), 30);
        cycle(0, 1, 0, 0, 1);
        check("t4_resume", int'(motor_dir), 2);
        idle(5);
        check("t4_before_dec", int'(remain_sec), 30);
        idle(1);
        check("t4_dec", int'(remain_sec), 29);
        cycle(0, 0, 1, 0, 1); cycle(0, 0, 1, 0, 1);
        check("t4_stop_clear", int'(remain_sec), 0);
        check("t4_stop_busy", int'(busy), 0);

        cycle(0, 0, 0, 1, 1); cycle(0, 0, 0, 1, 1);
        check("t5_level1", int'(level), 1);
        cycle(1, 0, 0, 0, 1); cycle(0, 1, 0, 0, 1);
        highs = 0;
        repeat (16) begin cycle(0, 0, 0, 0, 1); highs += int'(pwm_out); end
        check("t5_duty_l1", highs, 8);
        cycle(0, 0, 0, 1, 1);
        check("t5_level_run", int'(level), 1);
        cycle(0, 0, 1, 0, 1); cycle(0, 0, 1, 0, 1);
        cycle(0, 0, 0, 1, 1); cycle(0, 0, 0, 1, 1);
        check("t5_level3", int'(level), 3);
        cycle(1, 0, 0, 0, 1); cycle(0, 1, 0, 0, 1);
        highs = 0;
        repeat (16) begin cycle(0, 0, 0, 0, 1); highs += int'(pwm_out); end
        check("t5_duty_l3", highs, 16);

        cycle(0, 1, 1, 0, 1);
        check("t6_prio_busy", int'(busy), 1);
        check("t6_prio_motor", int'(motor_dir), 0);
        cycle(0, 1, 0, 0, 1);
        check("t6_run_again", int'(motor_dir), 2);
        cycle(0, 0, 0, 0, 0);
        check("t6_sw_remain", int'(remain_sec), 0);
        check("t6_sw_pwm", int'(pwm_out), 0);
        check("t6_sw_busy", int'(busy), 0);
        check("t6_sw_level", int'(level), 3);

        for (int b = 0; b < 30; b++) begin
            rate = $urandom_range(60, 4);
            for (int i = 0; i < 200; i++) begin
                a = 0; st = 0; sp = 0; lv = 0; sw = 1;
                if ($urandom_range(rate - 1, 0) == 0) begin
                    pick = $urandom_range(3, 0);
                    a = (pick == 0); st = (pick == 1); sp = (pick == 2); lv = (pick == 3);
                end
                if ($urandom_range(999, 0) == 0) sw = 0;
                cycle(a, st, sp, lv, sw);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
